// File: rtl/dmem_pkg.sv
// Shared types and default parameters for the data-memory controller.
// Holds the controller FSM state enum and default DW/AW/INIT values.
package dmem_pkg;

  localparam int DW_DEF       = 8;
  localparam int AW_DEF       = 8;
  localparam int INIT_TOP_DEF = 23;
  localparam int INIT_NXT_DEF = 17;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/dmem_ram.sv
// Unreset word RAM: one sync byte-enabled write port, one sync read port.
// Ports: clk_i, we_i/waddr_i/wdata_i/be_i (write), re_i/raddr_i/rdata_o (read).
module dmem_ram #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [DW/8-1:0] be_i,
  input  logic            re_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [DW-1:0]   rdata_o
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NB; i++) begin
      if (we_i && be_i[i]) begin
        mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: init sweep after reset, then 1-cycle read/write.
// Ports: clk, rst_n, req_* (valid/ready request), rsp_* (read resp), init_busy.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter int INIT_TOP = INIT_TOP_DEF,
  parameter int INIT_NXT = INIT_NXT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [DW/8-1:0] req_be,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic            init_busy
);

  localparam logic [AW-1:0] TOP_A = {AW{1'b1}};
  localparam logic [AW-1:0] NXT_A = TOP_A - AW'(1);
  localparam logic [DW-1:0] TOP_V = DW'(INIT_TOP);
  localparam logic [DW-1:0] NXT_V = DW'(INIT_NXT);

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            has_q, has_d;

  logic            we;
  logic            re;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] be;
  logic [DW-1:0]   ram_rdata;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    we          = 1'b0;
    re          = 1'b0;
    waddr       = req_addr;
    wdata       = req_wdata;
    be          = req_be;
    unique case (state_q)
      INIT: begin
        we    = 1'b1;
        waddr = cnt_q;
        be    = '1;
        if (cnt_q == TOP_A) begin
          wdata = TOP_V;
        end else if (cnt_q == NXT_A) begin
          wdata = NXT_V;
        end else begin
          wdata = '0;
        end
        if (cnt_q == TOP_A) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      RUN: begin
        if (req_valid) begin
          we = req_write;
          re = ~req_write;
        end
        rsp_valid_d = re;
      end
      default: ;
    endcase
    // The RAM read register has no reset, so rsp_rdata reads as 0
    // until the first read after reset has landed.
    has_d = has_q | re;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      has_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      has_q       <= has_d;
    end
  end

  dmem_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .be_i    (be),
    .re_i    (re),
    .raddr_i (req_addr),
    .rdata_o (ram_rdata)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = has_q ? ram_rdata : '0;
  assign init_busy = (state_q == INIT);
  assign req_ready = (state_q == RUN);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: vector table, directed corners,
// randomized traffic against a flat array model, plus a DW=32/AW=4 instance.
module tb_dmem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       a_req_valid, a_req_ready, a_req_write;
  logic [7:0] a_req_addr, a_req_wdata;
  logic [0:0] a_req_be;
  logic       a_rsp_valid, a_init_busy;
  logic [7:0] a_rsp_rdata;

  logic        b_rst_n;
  logic        b_req_valid, b_req_ready, b_req_write;
  logic [3:0]  b_req_addr;
  logic [31:0] b_req_wdata;
  logic [3:0]  b_req_be;
  logic        b_rsp_valid, b_init_busy;
  logic [31:0] b_rsp_rdata;

  dmem_ctrl u_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (a_req_valid),
    .req_ready (a_req_ready),
    .req_write (a_req_write),
    .req_addr  (a_req_addr),
    .req_wdata (a_req_wdata),
    .req_be    (a_req_be),
    .rsp_valid (a_rsp_valid),
    .rsp_rdata (a_rsp_rdata),
    .init_busy (a_init_busy)
  );

  dmem_ctrl #(.DW(32), .AW(4)) u_b (
    .clk       (clk),
    .rst_n     (b_rst_n),
    .req_valid (b_req_valid),
    .req_ready (b_req_ready),
    .req_write (b_req_write),
    .req_addr  (b_req_addr),
    .req_wdata (b_req_wdata),
    .req_be    (b_req_be),
    .rsp_valid (b_rsp_valid),
    .rsp_rdata (b_rsp_rdata),
    .init_busy (b_init_busy)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] model [256];
  logic [7:0] last_rd;

  typedef struct {
    logic       v;
    logic       w;
    logic [7:0] ad;
    logic [7:0] d;
    logic       b;
    logic       ev;
    logic [7:0] ed;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(logic v, logic w, logic [7:0] ad,
                              logic [7:0] d, logic b, logic ev,
                              logic [7:0] ed);
    vec_t r;
    r.v = v; r.w = w; r.ad = ad; r.d = d;
    r.b = b; r.ev = ev; r.ed = ed;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_init();
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    model[254] = 8'd17;
    model[255] = 8'd23;
  endtask

  task automatic a_drive(input logic v, input logic w, input logic [7:0] ad,
                         input logic [7:0] d, input logic b);
    a_req_valid = v;
    a_req_write = w;
    a_req_addr  = ad;
    a_req_wdata = d;
    a_req_be    = b;
  endtask

  // Counts edges until init_busy falls; optionally plants an INIT-time
  // write to address 3 late in the sweep that must be ignored.
  task automatic a_wait_init(output int n, output int sp);
    n  = 0;
    sp = 0;
    while (a_init_busy && n < 400) begin
      if (n == 200) a_drive(1'b1, 1'b1, 8'd3, 8'hEE, 1'b1);
      cyc();
      n++;
      if (a_rsp_valid) sp++;
    end
    a_drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
  endtask

  task automatic a_op(input string nm, input logic v, input logic w,
                      input logic [7:0] ad, input logic [7:0] d,
                      input logic b);
    logic ev;
    a_drive(v, w, ad, d, b);
    cyc();
    ev = v && !w;
    if (ev) last_rd = model[ad];
    if (v && w && b) model[ad] = d;
    chk({nm, "_valid"}, {31'd0, a_rsp_valid}, {31'd0, ev});
    chk({nm, "_data"}, {24'd0, a_rsp_rdata}, {24'd0, last_rd});
  endtask

  task automatic b_op(input logic v, input logic w, input logic [3:0] ad,
                      input logic [31:0] d, input logic [3:0] b);
    b_req_valid = v;
    b_req_write = w;
    b_req_addr  = ad;
    b_req_wdata = d;
    b_req_be    = b;
    cyc();
  endtask

  initial begin
    int n;
    int sp;
    logic       rv, rw, rb;
    logic [7:0] ra, rd;

    rst_n   = 1'b0;
    b_rst_n = 1'b0;
    a_drive(1'b1, 1'b0, 8'd3, 8'd0, 1'b0);
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0;
    b_req_wdata = '0;   b_req_be    = '0;

    tbl[0]  = mk(1'b1, 1'b0, 8'd254, 8'h00, 1'b0, 1'b1, 8'd17);
    tbl[1]  = mk(1'b1, 1'b0, 8'd255, 8'h00, 1'b0, 1'b1, 8'd23);
    tbl[2]  = mk(1'b1, 1'b0, 8'd0,   8'h00, 1'b0, 1'b1, 8'h00);
    tbl[3]  = mk(1'b1, 1'b0, 8'd3,   8'h00, 1'b0, 1'b1, 8'h00);
    tbl[4]  = mk(1'b1, 1'b1, 8'd7,   8'h5A, 1'b1, 1'b0, 8'h00);
    tbl[5]  = mk(1'b1, 1'b0, 8'd7,   8'h00, 1'b0, 1'b1, 8'h5A);
    tbl[6]  = mk(1'b1, 1'b1, 8'd9,   8'h12, 1'b0, 1'b0, 8'h5A);
    tbl[7]  = mk(1'b1, 1'b0, 8'd9,   8'h00, 1'b0, 1'b1, 8'h00);
    tbl[8]  = mk(1'b1, 1'b1, 8'd5,   8'h33, 1'b1, 1'b0, 8'h00);
    tbl[9]  = mk(1'b1, 1'b0, 8'd5,   8'h00, 1'b0, 1'b1, 8'h33);
    tbl[10] = mk(1'b0, 1'b0, 8'd0,   8'h00, 1'b0, 1'b0, 8'h33);
    tbl[11] = mk(1'b1, 1'b1, 8'd255, 8'h44, 1'b1, 1'b0, 8'h33);
    tbl[12] = mk(1'b1, 1'b0, 8'd255, 8'h00, 1'b0, 1'b1, 8'h44);
    tbl[13] = mk(1'b0, 1'b0, 8'd0,   8'h00, 1'b0, 1'b0, 8'h44);

    // Reset state
    repeat (2) cyc();
    chk("rst_busy",  {31'd0, a_init_busy}, 32'd1);
    chk("rst_ready", {31'd0, a_req_ready}, 32'd0);
    chk("rst_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("rst_rdata", {24'd0, a_rsp_rdata}, 32'd0);

    // Init sweep length, requests ignored during INIT
    rst_n = 1'b1;
    a_wait_init(n, sp);
    chk("init_len",  n, 256);
    chk("init_rsp",  sp, 0);
    chk("run_ready", {31'd0, a_req_ready}, 32'd1);
    model_init();
    last_rd = 8'h00;

    // Vector table
    for (int i = 0; i < 14; i++) begin
      a_drive(tbl[i].v, tbl[i].w, tbl[i].ad, tbl[i].d, tbl[i].b);
      cyc();
      chk($sformatf("tbl%0d_valid", i), {31'd0, a_rsp_valid},
          {31'd0, tbl[i].ev});
      chk($sformatf("tbl%0d_data", i), {24'd0, a_rsp_rdata},
          {24'd0, tbl[i].ed});
      if (tbl[i].v && tbl[i].w && tbl[i].b) model[tbl[i].ad] = tbl[i].d;
    end
    last_rd = 8'h44;

    // Back-to-back reads 0..9
    for (int k = 0; k < 10; k++) begin
      a_op("b2b_wr", 1'b1, 1'b1, 8'(k), 8'(k * 3 + 1), 1'b1);
    end
    for (int k = 0; k < 10; k++) begin
      a_op($sformatf("b2b_rd%0d", k), 1'b1, 1'b0, 8'(k), 8'h00, 1'b0);
    end
    a_op("b2b_idle", 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      rv = ($urandom % 4) != 0;
      rw = $urandom % 2;
      rb = $urandom % 2;
      rd = 8'($urandom);
      if ($urandom % 8 == 0) ra = 8'($urandom_range(248, 255));
      else ra = 8'($urandom_range(0, 15));
      a_op("rand", rv, rw, ra, rd, rb);
    end

    // Reset mid-read, then again at sweep cycle 100
    a_op("mr_wr", 1'b1, 1'b1, 8'd5, 8'h33, 1'b1);
    a_op("mr_rd", 1'b1, 1'b0, 8'd5, 8'h00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("mr_rdata", {24'd0, a_rsp_rdata}, 32'd0);
    chk("mr_busy",  {31'd0, a_init_busy}, 32'd1);
    chk("mr_ready", {31'd0, a_req_ready}, 32'd0);
    a_drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    cyc();
    rst_n = 1'b1;
    repeat (100) cyc();
    rst_n = 1'b0;
    #1;
    chk("m100_busy", {31'd0, a_init_busy}, 32'd1);
    cyc();
    rst_n = 1'b1;
    a_wait_init(n, sp);
    chk("reinit_len", n, 256);
    chk("reinit_rsp", sp, 0);
    model_init();
    last_rd = 8'h00;
    a_op("post_rd5",   1'b1, 1'b0, 8'd5,   8'h00, 1'b0);
    a_op("post_rd7",   1'b1, 1'b0, 8'd7,   8'h00, 1'b0);
    a_op("post_rd3",   1'b1, 1'b0, 8'd3,   8'h00, 1'b0);
    a_op("post_rd254", 1'b1, 1'b0, 8'd254, 8'h00, 1'b0);
    a_op("post_rd255", 1'b1, 1'b0, 8'd255, 8'h00, 1'b0);

    // Wide instance: byte-lane merge and zero-extended init values
    b_rst_n = 1'b1;
    n = 0;
    while (b_init_busy && n < 40) begin
      cyc();
      n++;
    end
    chk("b_init_len", n, 16);
    b_op(1'b1, 1'b1, 4'd3, 32'hAABBCCDD, 4'hF);
    chk("b_wr_valid", {31'd0, b_rsp_valid}, 32'd0);
    b_op(1'b1, 1'b1, 4'd3, 32'h11223344, 4'h5);
    b_op(1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
    chk("b_rd3_valid", {31'd0, b_rsp_valid}, 32'd1);
    chk("b_rd3_data",  b_rsp_rdata, 32'hAA22CC44);
    b_op(1'b1, 1'b0, 4'd15, 32'h0, 4'h0);
    chk("b_rd15", b_rsp_rdata, 32'd23);
    b_op(1'b1, 1'b0, 4'd14, 32'h0, 4'h0);
    chk("b_rd14", b_rsp_rdata, 32'd17);
    b_op(1'b1, 1'b0, 4'd0, 32'h0, 4'h0);
    chk("b_rd0", b_rsp_rdata, 32'd0);
    b_op(1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
    chk("b_idle_valid", {31'd0, b_rsp_valid}, 32'd0);
    chk("b_idle_hold",  b_rsp_rdata, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DW, default 8: data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter AW, default 8: address width; depth is 2**AW words.
REQ-003 Parameter INIT_TOP, default 23: value written to address 2**AW-1 during the init sweep.
REQ-004 Parameter INIT_NXT, default 17: value written to address 2**AW-2 during the init sweep.
REQ-005 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 Port req_valid, input, 1: a request is presented.
REQ-008 Port req_ready, output, 1: the block accepts a request this cycle.
REQ-009 Port req_write, input, 1: 1 means write, 0 means read.
REQ-010 Port req_addr, input, AW: word address.
REQ-011 Port req_wdata, input, DW: write data.
REQ-012 Port req_be, input, DW/8: byte-lane write enables; bit i covers bits 8i+7:8i.
REQ-013 Port rsp_valid, output, 1: rsp_rdata holds read data this cycle.
REQ-014 Port rsp_rdata, output, DW: registered read data.
REQ-015 Port init_busy, output, 1: the init sweep is in progress.

Function
REQ-016 The FSM SHALL have two states, INIT and RUN, and enter INIT on reset.
REQ-017 INIT behaviour:
- The address counter starts at 0 and advances by 1 per cycle.
- Each cycle writes 0 to the counted address, except address 2**AW-2, which gets INIT_NXT, and address 2**AW-1, which gets INIT_TOP.
- INIT values are truncated or zero-extended to DW.
REQ-018 INIT lasts exactly 2**AW cycles; after the write to address 2**AW-1, the FSM SHALL go to RUN on the next edge.
REQ-019 init_busy SHALL be 1 in INIT and 0 in RUN; req_ready SHALL be 0 in INIT and 1 in RUN.
REQ-020 A request is accepted when req_valid and req_ready are both 1 at a rising edge; requests presented in INIT are ignored.
REQ-021 An accepted write SHALL update only the byte lanes whose req_be bit is 1; a write with req_be all-zero SHALL be a no-op.
REQ-022 An accepted write SHALL NOT assert rsp_valid.
REQ-023 An accepted read SHALL produce rsp_valid=1 for exactly one cycle, on the cycle after acceptance (latency 1), with rsp_rdata = mem[req_addr].
REQ-024 rsp_rdata SHALL hold its last value while rsp_valid=0.
REQ-025 A read accepted in the cycle after a write to the same address SHALL return the newly written data, with no stale data.
REQ-026 Back-to-back reads, one per cycle, SHALL each return valid data, giving full throughput.
REQ-027 Address arithmetic SHALL wrap modulo 2**AW, and the init counter SHALL NOT exceed 2**AW-1.

Reset
REQ-028 On rst_n=0, the following SHALL take effect immediately (asynchronously): FSM=INIT, counter=0, rsp_valid=0, rsp_rdata=0, init_busy=1, req_ready=0.
REQ-029 The memory array SHALL NOT be reset directly; its contents are defined only by the init sweep.
REQ-030 If reset is asserted mid-INIT or mid-RUN, any pending response is cancelled and the sweep restarts from address 0 after release.

Structure
REQ-031 Package dmem_pkg SHALL hold the FSM state enum (INIT, RUN) and the default values of DW, AW, INIT_TOP and INIT_NXT.
REQ-032 The storage SHALL be a sub-module dmem_ram with these properties:
- parametrised DW/AW;
- one synchronous write port with byte enables;
- one synchronous read port;
- no reset.
REQ-033 The init sweep and requests SHALL share the single dmem_ram write port through a mux selected by FSM state.

Verification
REQ-034 Reset, then wait: init_busy stays 1 for 256 cycles with AW=8, then falls; reads of address 254 and 255 return 17 and 23; a read of address 0 returns 0.
REQ-035 With DW=32, AW=4: write 0xAABBCCDD to address 3 with be=0xF, then write 0x11223344 to address 3 with be=0x5; a read of address 3 returns 0xAA22CC44.
REQ-036 Write 0x5A to address 7, then read address 7 on the very next cycle: rsp_valid=1 one cycle later with data 0x5A.
REQ-037 Read addresses 0..9 back-to-back: rsp_valid is high for 10 consecutive cycles with in-order data; req_valid during INIT produces no response and no memory change.
REQ-038 Write 0x33 to address 5, assert rst_n=0 mid-read and again at sweep cycle 100:
- rsp_valid drops immediately;
- the sweep restarts at 0;
- address 5 reads 0 after init.
